// File: rtl/updown_pkg.sv
// Shared definitions for the up/down counter sequencer: state encoding, program modes, counter width.
package updown_pkg;

  localparam int COUNT_SIZE = 8;

  localparam logic [1:0] MODE_UP_ONCE = 2'b00;
  localparam logic [1:0] MODE_DN_ONCE = 2'b01;
  localparam logic [1:0] MODE_BOUNCE  = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN_UP = 2'd1,
    RUN_DN = 2'd2,
    FIN    = 2'd3
  } state_t;

endpackage

// File: rtl/seq_prescaler.sv
// Step-tick prescaler: counts 0..TICK_DIV-1 while run is high and freeze is low, tick on the last count.
module seq_prescaler #(
  parameter int TICK_DIV = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  input  logic freeze,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  assign tick = run && !freeze && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run && !freeze) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/updown_ctr_sequencer.sv
// Sequences the up/down counter through up-once, down-once or bounce programs between captured limits.
// Optional SEQ_PAUSE_EN adds a pause input that freezes the step prescaler while a program runs.
module updown_ctr_sequencer #(
  parameter int COUNT_SIZE = updown_pkg::COUNT_SIZE,
  parameter int TICK_DIV   = 5000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
`ifdef SEQ_PAUSE_EN
  input  logic                  pause,
`endif
  input  logic [1:0]            mode,
  input  logic [COUNT_SIZE-1:0] lo_limit,
  input  logic [COUNT_SIZE-1:0] hi_limit,
  input  logic [COUNT_SIZE-1:0] count_in,
  output logic                  ctr_en,
  output logic                  ctr_up_dn,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            dbg_state
);
  import updown_pkg::*;

  // start/stop are single-cycle strobes with no handshake; stop always beats start in the same cycle.
  state_t                state;
  logic [COUNT_SIZE-1:0] lo_q;
  logic [COUNT_SIZE-1:0] hi_q;
  logic [1:0]            mode_q;
  logic                  run;
  logic                  tick;
  logic                  paused;
  logic                  start_req;
  logic                  start_legal;
  logic                  start_ok;
  logic                  start_bad;
  logic                  bounce;
  logic                  flat;

`ifdef SEQ_PAUSE_EN
  assign paused = pause;
`else
  assign paused = 1'b0;
`endif

  assign run         = (state == RUN_UP) || (state == RUN_DN);
  assign busy        = run;
  assign done        = (state == FIN);
  assign dbg_state   = state;
  assign start_req   = (state == IDLE) && start && !stop;
  assign start_legal = (mode != 2'b11) && (lo_limit <= hi_limit);
  assign start_ok    = start_req && start_legal;
  assign start_bad   = start_req && !start_legal;
  assign bounce      = (mode_q == MODE_BOUNCE);
  assign flat        = (lo_q == hi_q);

  seq_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .clear  (start_ok),
    .run    (run),
    .freeze (paused),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      lo_q      <= '0;
      hi_q      <= '0;
      mode_q    <= '0;
      ctr_en    <= 1'b0;
      ctr_up_dn <= 1'b1;
      err       <= 1'b0;
    end else begin
      ctr_en <= 1'b0;
      err    <= start_bad;
      case (state)
        IDLE: begin
          if (start_ok) begin
            lo_q   <= lo_limit;
            hi_q   <= hi_limit;
            mode_q <= mode;
            state  <= (mode == MODE_DN_ONCE) ? RUN_DN : RUN_UP;
          end
        end
        RUN_UP: begin
          if (stop) begin
            state <= IDLE;
          end else if (tick && !(bounce && flat)) begin
            if (count_in < hi_q) begin
              ctr_en    <= 1'b1;
              ctr_up_dn <= 1'b1;
            end else if (!bounce) begin
              state <= FIN;
            end else begin
              // Turn around on the same tick that sees the limit, so the bounce never dwells.
              state     <= RUN_DN;
              ctr_en    <= 1'b1;
              ctr_up_dn <= 1'b0;
            end
          end
        end
        RUN_DN: begin
          if (stop) begin
            state <= IDLE;
          end else if (tick && !(bounce && flat)) begin
            if (count_in > lo_q) begin
              ctr_en    <= 1'b1;
              ctr_up_dn <= 1'b0;
            end else if (!bounce) begin
              state <= FIN;
            end else begin
              state     <= RUN_UP;
              ctr_en    <= 1'b1;
              ctr_up_dn <= 1'b1;
            end
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_updown_ctr_sequencer.sv
// Bench for updown_ctr_sequencer: a counter model closes the feedback loop, a timeline model predicts outputs.
module tb_updown_ctr_sequencer;
  import updown_pkg::*;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] lo_limit = 8'd0;
  logic [7:0] hi_limit = 8'd0;
  logic [7:0] count_in;
  logic       ctr_en;
  logic       ctr_up_dn;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] dbg_state;
`ifdef SEQ_PAUSE_EN
  logic       pause = 1'b0;
`endif

  int         n_checks = 0;
  int         n_fail = 0;
  logic       last_dir = 1'b1;
  logic [4:0] exp_q[$];

  // Counter datapath stand-in: loads a preset, otherwise steps on ctr_en.
  logic [7:0] cnt_val;
  logic       ld = 1'b0;
  logic [7:0] ld_val = 8'd0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld) cnt_val <= ld_val;
    else if (ctr_en) cnt_val <= ctr_up_dn ? cnt_val + 8'd1 : cnt_val - 8'd1;
  end
  assign count_in = cnt_val;

  updown_ctr_sequencer #(
    .COUNT_SIZE (8),
    .TICK_DIV   (T)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
`ifdef SEQ_PAUSE_EN
    .pause     (pause),
`endif
    .mode      (mode),
    .lo_limit  (lo_limit),
    .hi_limit  (hi_limit),
    .count_in  (count_in),
    .ctr_en    (ctr_en),
    .ctr_up_dn (ctr_up_dn),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One program: preload the counter, predict every cycle from the step rules, then drive and compare.
  // Outputs are packed {ctr_en, ctr_up_dn, busy, done, err}; edge j=0 is the edge that samples start.
  task automatic run_prog(input string tag, input logic [1:0] m, input int lo, input int hi,
                          input int c0, input int ncyc, input int stop_at, input int rst_at,
                          input int st2_at, input int pa, input int pb);
    int   pos;
    int   unp;
    bit   active;
    bit   up;
    bit   legal;
    bit   taken;
    logic dir;
    logic e;
    logic dn;
    logic er;

    ld     = 1'b1;
    ld_val = 8'(c0);
    @(negedge clk);
    ld     = 1'b0;

    legal  = (m != 2'b11) && (lo <= hi);
    taken  = (stop_at != 0) && (rst_at != 0);
    active = legal && taken;
    up     = (m != 2'b01);
    pos    = c0;
    unp    = 0;
    dir    = last_dir;
    for (int j = 0; j < ncyc; j++) begin
      e  = 1'b0;
      dn = 1'b0;
      er = (j == 0) && taken && !legal;
      if (j == rst_at) begin
        active = 1'b0;
        dir    = 1'b1;
      end else if (active && j > 0) begin
        if (j == stop_at) begin
          active = 1'b0;
        end else if (!(j >= pa && j < pb)) begin
          unp++;
          if (unp % T == 0 && !(m == 2'b10 && lo == hi)) begin
            if (up) begin
              if (pos < hi) begin e = 1'b1; dir = 1'b1; pos++; end
              else if (m == 2'b00) begin active = 1'b0; dn = 1'b1; end
              else begin up = 1'b0; e = 1'b1; dir = 1'b0; pos--; end
            end else begin
              if (pos > lo) begin e = 1'b1; dir = 1'b0; pos--; end
              else if (m == 2'b01) begin active = 1'b0; dn = 1'b1; end
              else begin up = 1'b1; e = 1'b1; dir = 1'b1; pos++; end
            end
          end
        end
      end
      exp_q.push_back({e, dir, active, dn, er});
    end
    last_dir = dir;

    lo_limit = 8'(lo);
    hi_limit = 8'(hi);
    for (int j = 0; j < ncyc; j++) begin
      logic [4:0] exp_w;
      start = (j == 0) || (j == st2_at);
      mode  = (j == st2_at) ? 2'b11 : m;
      stop  = (j == stop_at);
      reset = (j != rst_at);
`ifdef SEQ_PAUSE_EN
      pause = (j >= pa && j < pb);
`endif
      @(negedge clk);
      exp_w = exp_q.pop_front();
      check($sformatf("%s@%0d", tag, j), {27'd0, ctr_en, ctr_up_dn, busy, done, err}, {27'd0, exp_w});
    end
    start = 1'b0;
    stop  = 1'b0;
    reset = 1'b1;
`ifdef SEQ_PAUSE_EN
    pause = 1'b0;
`endif
    check({tag, "_count"}, {24'd0, cnt_val}, 32'(pos));
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out", {27'd0, ctr_en, ctr_up_dn, busy, done, err}, 32'b01000);
    check("rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
    reset = 1'b1;
    last_dir = 1'b1;

    run_prog("up_once",    2'b00, 0, 3,  0, 24, -1, -1, -1, -1, -1);
    run_prog("dn_once",    2'b01, 1, 5,  5, 24, -1, -1, -1, -1, -1);
    run_prog("bounce",     2'b10, 2, 5,  2, 52, 48, -1, -1, -1, -1);
    run_prog("busy_start", 2'b00, 0, 4,  0, 28, -1, -1,  6, -1, -1);
    run_prog("bad_lim",    2'b00, 7, 3,  3,  6, -1, -1, -1, -1, -1);
    run_prog("bad_mode",   2'b11, 0, 3,  0,  6, -1, -1, -1, -1, -1);
    run_prog("abort",      2'b00, 0, 10, 0, 20, 10, -1, -1, -1, -1);
    run_prog("stop_start", 2'b00, 0, 3,  0,  6,  0, -1, -1, -1, -1);
    run_prog("rst_mid",    2'b01, 0, 9,  9, 20, -1,  9, -1, -1, -1);
    run_prog("flat_bnc",   2'b10, 6, 6,  6, 20, 18, -1, -1, -1, -1);
`ifdef SEQ_PAUSE_EN
    run_prog("pause",      2'b00, 0, 5,  0, 48, -1, -1, -1,  6, 16);
`endif

    for (int i = 0; i < 10; i++) begin
      logic [1:0] m;
      int lo, hi, c0, ncyc, sa;
      m  = 2'($urandom_range(3, 0));
      lo = $urandom_range(15, 0);
      hi = $urandom_range(15, 0);
      c0 = (lo <= hi) ? $urandom_range(hi, lo) : lo;
      if (m == 2'b11 || lo > hi) ncyc = 6;
      else ncyc = T * (((hi > lo) ? hi - lo : 0) + 3) + 4;
      sa = -1;
      if (ncyc > 6 && (m == 2'b10 || $urandom_range(1, 0) == 1)) sa = $urandom_range(ncyc - 2, 1);
      run_prog($sformatf("rnd%0d", i), m, lo, hi, c0, ncyc, sa, -1, -1, -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
